// File: rtl/perf_event_monitor_if.sv
// Bus bundle for perf_event_monitor: control strobes, event inputs, read port and status.
interface perf_event_monitor_if #(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned CNT_WIDTH  = 32
);
  localparam int unsigned SEL_W = $clog2(NUM_EVENTS + 1);

  logic                  start_i;
  logic                  clear_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic [NUM_EVENTS-1:0] inhibit_i;
  logic                  snap_i;
  logic                  rd_en_i;
  logic [SEL_W-1:0]      rd_sel_i;
  logic [CNT_WIDTH-1:0]  rd_data_o;
  logic                  rd_valid_o;
  logic [NUM_EVENTS:0]   overflow_o;
  logic                  running_o;
  logic                  done_o;

  modport master (
    output start_i, clear_i, event_i, inhibit_i, snap_i, rd_en_i, rd_sel_i,
    input  rd_data_o, rd_valid_o, overflow_o, running_o, done_o
  );

  modport slave (
    input  start_i, clear_i, event_i, inhibit_i, snap_i, rd_en_i, rd_sel_i,
    output rd_data_o, rd_valid_o, overflow_o, running_o, done_o
  );
endinterface

// File: rtl/perf_event_monitor.sv
// Performance event monitor: NUM_EVENTS qualified event counters plus a cycle counter,
// budgeted auto-stop, shadow snapshot bank and registered read port.
module perf_event_monitor #(
  parameter int unsigned NUM_EVENTS  = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned CYCLE_LIMIT = 64,
  localparam int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input logic                 clk_i,
  input logic                 rst_i,
  perf_event_monitor_if.slave bus
);

  localparam bit                   LIMITED = (CYCLE_LIMIT != 0);
  localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(LIMITED ? CYCLE_LIMIT - 1 : 0);
  localparam logic [SEL_W-1:0]     CYC_SEL = SEL_W'(NUM_EVENTS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic                 running;
  logic                 done;
  logic [CNT_WIDTH-1:0] live   [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS+1];
  logic [NUM_EVENTS:0]  overflow;
  logic [NUM_EVENTS:0]  hit;
  logic                 budget_hit;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_valid;

  // Top bit is the cycle counter, which advances on every RUN edge.
  assign hit        = {1'b1, bus.event_i & ~bus.inhibit_i};
  assign budget_hit = LIMITED && (live[NUM_EVENTS] == LAST);

  // Control FSM; running/done are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (bus.clear_i) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start_i) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (budget_hit) begin
          state   <= DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end else if (!bus.start_i) begin
          state   <= IDLE;
          running <= 1'b0;
        end
        DONE: ;
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Live counters with saturation, sticky overflow, and snapshot into the shadow bank.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k <= NUM_EVENTS; k++) begin
        live[k]   <= '0;
        shadow[k] <= '0;
      end
      overflow <= '0;
    end else if (bus.clear_i) begin
      for (int unsigned k = 0; k <= NUM_EVENTS; k++) begin
        live[k]   <= '0;
        shadow[k] <= '0;
      end
      overflow <= '0;
    end else begin
      // Snapshot takes the pre-increment values because both use the old live[].
      if (bus.snap_i) begin
        for (int unsigned k = 0; k <= NUM_EVENTS; k++) shadow[k] <= live[k];
      end
      if (state == RUN) begin
        for (int unsigned k = 0; k <= NUM_EVENTS; k++) begin
          if (hit[k]) begin
            if (live[k] == '1) overflow[k] <= 1'b1;
            else               live[k]     <= live[k] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Registered read of the shadow bank; out-of-range selects return zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data <= (bus.rd_sel_i <= CYC_SEL) ? shadow[bus.rd_sel_i] : '0;
    end
  end

  assign bus.rd_data_o  = rd_data;
  assign bus.rd_valid_o = rd_valid;
  assign bus.overflow_o = overflow;
  assign bus.running_o  = running;
  assign bus.done_o     = done;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: two instances (32-bit/limit 64 and 4-bit/unlimited) share
// directed stimulus and are compared every cycle against a counting model, with literal pins.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, clear = 1'b0, snap = 1'b0, rd_en = 1'b0;
  logic [3:0] ev = '0, inh = '0;
  logic [2:0] sel = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_event_monitor_if #(.NUM_EVENTS(4), .CNT_WIDTH(32)) b0 ();
  perf_event_monitor_if #(.NUM_EVENTS(4), .CNT_WIDTH(4))  b1 ();

  assign b0.start_i = start;  assign b1.start_i = start;
  assign b0.clear_i = clear;  assign b1.clear_i = clear;
  assign b0.event_i = ev;     assign b1.event_i = ev;
  assign b0.inhibit_i = inh;  assign b1.inhibit_i = inh;
  assign b0.snap_i = snap;    assign b1.snap_i = snap;
  assign b0.rd_en_i = rd_en;  assign b1.rd_en_i = rd_en;
  assign b0.rd_sel_i = sel;   assign b1.rd_sel_i = sel;

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(32), .CYCLE_LIMIT(64)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .bus(b0.slave));
  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4), .CYCLE_LIMIT(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .bus(b1.slave));

  // Model: index 4 of each counter set is the elapsed-cycle counter.
  longint cnt [2][5];
  longint shd [2][5];
  bit     ovf [2][5];
  longint rdd [2];
  bit     rdv [2];
  bit     counting [2];
  bit     finished [2];
  longint maxv [2] = '{64'd4294967295, 64'd15};
  longint lim  [2] = '{64'd64, 64'd0};

  always @(posedge clk or negedge rst_n) begin
    bit last;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 5; k++) begin cnt[d][k] = 0; shd[d][k] = 0; ovf[d][k] = 0; end
        rdd[d] = 0; rdv[d] = 0; counting[d] = 0; finished[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        rdv[d] = rd_en;
        if (rd_en) rdd[d] = (sel <= 4) ? shd[d][sel] : 0;
        if (clear) begin
          for (int k = 0; k < 5; k++) begin cnt[d][k] = 0; shd[d][k] = 0; ovf[d][k] = 0; end
          counting[d] = 0; finished[d] = 0;
        end else begin
          if (snap) for (int k = 0; k < 5; k++) shd[d][k] = cnt[d][k];
          if (counting[d]) begin
            last = (lim[d] != 0) && (cnt[d][4] == lim[d] - 1);
            for (int k = 0; k < 5; k++) begin
              if (k == 4 || (ev[k] && !inh[k])) begin
                if (cnt[d][k] == maxv[d]) ovf[d][k] = 1;
                else cnt[d][k] = cnt[d][k] + 1;
              end
            end
            if (last) begin counting[d] = 0; finished[d] = 1; end
            else if (!start) counting[d] = 0;
          end else if (!finished[d] && start) begin
            counting[d] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [4:0] ov0, ov1;
    for (int k = 0; k < 5; k++) begin ov0[k] = ovf[0][k]; ov1[k] = ovf[1][k]; end
    chk("running0",  64'(b0.running_o),  64'(counting[0]));
    chk("done0",     64'(b0.done_o),     64'(finished[0]));
    chk("overflow0", 64'(b0.overflow_o), 64'(ov0));
    chk("rd_valid0", 64'(b0.rd_valid_o), 64'(rdv[0]));
    chk("rd_data0",  64'(b0.rd_data_o),  rdd[0]);
    chk("running1",  64'(b1.running_o),  64'(counting[1]));
    chk("done1",     64'(b1.done_o),     64'(finished[1]));
    chk("overflow1", 64'(b1.overflow_o), 64'(ov1));
    chk("rd_valid1", 64'(b1.rd_valid_o), 64'(rdv[1]));
    chk("rd_data1",  64'(b1.rd_data_o),  rdd[1]);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_snap();
    snap = 1'b1; tick(); snap = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic rd_lit(input logic [2:0] s, input bit which, input logic [63:0] exp,
                        input string name);
    rd_en = 1'b1; sel = s; tick(); rd_en = 1'b0;
    chk(name, which ? 64'(b1.rd_data_o) : 64'(b0.rd_data_o), exp);
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    chk("reset_running", 64'(b0.running_o), 64'd0);
    chk("reset_done",    64'(b0.done_o),    64'd0);

    // Async reset in the middle of a run.
    start = 1'b1; ev = 4'b0001;
    tick(5);
    do_snap();
    rd_lit(3'd0, 1'b0, 64'd4, "pre_reset_ch0");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_data",  64'(b0.rd_data_o),  64'd0);
    chk("async_rd_valid", 64'(b0.rd_valid_o), 64'd0);
    chk("async_running",  64'(b0.running_o),  64'd0);
    start = 1'b0; ev = '0;
    tick();
    rst_n = 1'b1;

    // Budget of 64 counted cycles with an event every cycle.
    start = 1'b1; ev = 4'b0001;
    for (int i = 0; i < 200 && !b0.done_o; i++) tick();
    chk("budget_done", 64'(b0.done_o), 64'd1);
    tick(5);
    chk("done_holds", 64'(b0.done_o), 64'd1);
    do_snap();
    rd_lit(3'd4, 1'b0, 64'd64, "budget_cycles");
    rd_lit(3'd0, 1'b0, 64'd64, "budget_ch0");

    // clear + snap + start on one edge; out-of-range select.
    ev = '0; clear = 1'b1; snap = 1'b1;
    tick();
    clear = 1'b0; snap = 1'b0;
    chk("clr_running",  64'(b0.running_o),  64'd0);
    chk("clr_done",     64'(b0.done_o),     64'd0);
    chk("clr_overflow", 64'(b1.overflow_o), 64'd0);
    tick();
    chk("clr_then_run", 64'(b0.running_o), 64'd1);
    rd_lit(3'd7, 1'b0, 64'd0, "sel7_zero");

    // Inhibited events on channel 1.
    start = 1'b0;
    do_clear();
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      ev  = 4'b0010;
      inh = (i == 2 || i == 5 || i == 7) ? 4'b0010 : 4'b0000;
      tick();
    end
    ev = '0; inh = '0; start = 1'b0;
    tick();
    do_snap();
    rd_lit(3'd1, 1'b0, 64'd7,  "inhibit_ch1");
    rd_lit(3'd4, 1'b0, 64'd11, "inhibit_cycles");

    // Pause and resume.
    do_clear();
    start = 1'b1; tick(11);
    start = 1'b0; tick(5);
    start = 1'b1; tick(7);
    start = 1'b0; tick();
    do_snap();
    rd_lit(3'd4, 1'b0, 64'd18, "pause_cycles");

    // Saturation on the 4-bit instance.
    do_clear();
    start = 1'b1; ev = 4'b0001;
    tick(21);
    start = 1'b0; ev = '0;
    tick();
    do_snap();
    rd_lit(3'd0, 1'b1, 64'd15, "sat_ch0");
    chk("sat_ovf0", 64'(b1.overflow_o[0]), 64'd1);
    tick(3);
    chk("sat_ovf0_sticky", 64'(b1.overflow_o[0]), 64'd1);
    do_clear();
    chk("sat_ovf_cleared", 64'(b1.overflow_o), 64'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
